// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Frame errors pulse for one cycle; FIFO overflow is sticky until clr_i or reset.
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 32,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rx_i,
  input  logic                             rx_en_i,
  input  logic                             clr_i,
  output logic [7:0]                       data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  output logic                             frame_err_o,
  output logic                             overflow_o,
  output logic [2:0]                       fsm_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          push, ferr_d;
  logic          sync1, rxs;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          overflow;
  logic          pop, full, push_ok;

  // Two-flop synchroniser; reset to the idle line level so no false start appears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_d;
      shreg       <= shreg_d;
      frame_err_o <= ferr_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    bit_d   = bit_idx;
    shreg_d = shreg;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check rejects short low glitches.
        if (cnt == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d           = '0;
          shreg_d[bit_idx] = rxs;
          bit_d           = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (!rx_en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      push    = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  // Handshake: the head byte transfers on any cycle with valid_o && ready_i;
  // a pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign pop     = ready_i && (count != '0);
  assign full    = (count == DEPTH_N);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst_n && !clr_i && push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + NW'(1);
      else if (!push_ok && pop) count <= count - NW'(1);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  assign valid_o    = (count != '0);
  assign data_o     = valid_o ? mem[rd_ptr] : 8'h00;
  assign count_o    = count;
  assign overflow_o = overflow;
  assign fsm_state  = state;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: table of single frames plus hand-built
// sequences for glitch, break, overflow, simultaneous push/pop and abort cases.
module tb_uart_rx_capture;

  localparam int C = 32;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n, rx_i, rx_en_i, clr_i, ready_i;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overflow_o;
  logic [4:0] count_o;
  logic [2:0] fsm_state;

  uart_rx_capture #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_en_i(rx_en_i), .clr_i(clr_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int valid_cycles = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_push;
    int         exp_err;
  } vec_t;
  vec_t vecs[6];

  // Collector samples between the input drive (negedge+1) and the next posedge.
  always @(negedge clk) begin
    #3;
    if (valid_o) valid_cycles++;
    if (valid_o && ready_i) got_q.push_back(data_o);
    if (frame_err_o) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_i = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      wait_cycles(C);
    end
    rx_i = stop;
    wait_cycles(C);
    rx_i = 1'b1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    err_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic check_scoreboard(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    vecs[0] = '{8'h65, 1'b1, 1, 0};
    vecs[1] = '{8'hA5, 1'b0, 0, 1};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'h81, 1'b0, 0, 1};
    vecs[5] = '{8'h3C, 1'b1, 1, 0};

    rst_n = 1'b0; rx_i = 1'b1; rx_en_i = 1'b1; clr_i = 1'b0; ready_i = 1'b1;
    wait_cycles(3);
    check("rst_valid", valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_data", data_o, 8'h00);
    check("rst_state", fsm_state, 0);
    rst_n = 1'b1;
    wait_cycles(4);

    // Single frames with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      send_frame(vecs[v].data, vecs[v].stop);
      wait_cycles(3 * C);
      check($sformatf("vec%0d_pushes", v), got_q.size(), vecs[v].exp_push);
      if (vecs[v].exp_push == 1 && got_q.size() == 1)
        check($sformatf("vec%0d_data", v), got_q[0], vecs[v].data);
      check($sformatf("vec%0d_valid_cycles", v), valid_cycles, vecs[v].exp_push);
      check($sformatf("vec%0d_ferr", v), err_cnt, vecs[v].exp_err);
      check($sformatf("vec%0d_count", v), count_o, 0);
    end

    // Short low glitch on the line.
    clear_obs();
    rx_i = 1'b0;
    wait_cycles(5);
    rx_i = 1'b1;
    wait_cycles(2 * C);
    check("glitch_pushes", got_q.size(), 0);
    check("glitch_ferr", err_cnt, 0);
    check("glitch_state", fsm_state, 0);

    // Bad stop bit, line held low 20 bit-times, then a good byte.
    clear_obs();
    send_frame(8'hA5, 1'b0);
    rx_i = 1'b0;
    wait_cycles(20 * C);
    check("break_state", fsm_state, 3'd4);
    rx_i = 1'b1;
    wait_cycles(2 * C);
    send_frame(8'h3C, 1'b1);
    wait_cycles(2 * C);
    exp_q.push_back(8'h3C);
    check_scoreboard("break");
    check("break_ferr", err_cnt, 1);

    // Overflow: 17 bytes into a 16-deep FIFO with no consumer.
    clear_obs();
    ready_i = 1'b0;
    for (int i = 0; i < 17; i++) send_frame(i[7:0], 1'b1);
    wait_cycles(2 * C);
    check("ovf_count", count_o, 16);
    check("ovf_flag", overflow_o, 1);
    check("ovf_head", data_o, 8'h00);
    check("ovf_valid", valid_o, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(i[7:0]);
    ready_i = 1'b1;
    wait_cycles(24);
    check_scoreboard("ovf_drain");
    check("ovf_drained_count", count_o, 0);
    check("ovf_sticky", overflow_o, 1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("ovf_cleared", overflow_o, 0);

    // Full FIFO, pop exactly on the stop-sample cycle of 0x77.
    clear_obs();
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send_frame(8'h20 + i[7:0], 1'b1);
    wait_cycles(C);
    check("pp_full_count", count_o, 16);
    fork
      send_frame(8'h77, 1'b1);
      begin
        wait_cycles(2 + C / 2 + 9 * C);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
      end
    join
    wait_cycles(2 * C);
    check("pp_count", count_o, 16);
    check("pp_ovf", overflow_o, 0);
    check("pp_head", data_o, 8'h21);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h20 + i[7:0]);
    exp_q.push_back(8'h77);
    ready_i = 1'b1;
    wait_cycles(24);
    check_scoreboard("pp");

    // clr_i flushes held bytes.
    clear_obs();
    ready_i = 1'b0;
    send_frame(8'h99, 1'b1);
    wait_cycles(C);
    check("clr_pre_count", count_o, 1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_count", count_o, 0);
    check("clr_valid", valid_o, 0);
    ready_i = 1'b1;

    // Abort at data bit 4 by rx_en_i, then by reset; 0x5A follows each time.
    for (int mode = 0; mode < 2; mode++) begin
      clear_obs();
      rx_i = 1'b0;
      wait_cycles(C);
      for (int i = 0; i < 4; i++) begin
        rx_i = 1'b1;
        wait_cycles(C);
      end
      rx_i = 1'b0;
      wait_cycles(C / 2);
      if (mode == 0) rx_en_i = 1'b0;
      else rst_n = 1'b0;
      wait_cycles(4);
      rx_i = 1'b1;
      wait_cycles(C);
      rx_en_i = 1'b1;
      rst_n = 1'b1;
      wait_cycles(C);
      check($sformatf("abort%0d_state", mode), fsm_state, 0);
      send_frame(8'h5A, 1'b1);
      wait_cycles(2 * C);
      exp_q.push_back(8'h5A);
      check_scoreboard($sformatf("abort%0d", mode));
      check($sformatf("abort%0d_ferr", mode), err_cnt, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
